led_rate_scheduler: RTL and testbench

Controller for the board's LED blink datapath: debounces the rate switches, enable and auto-mode inputs, then drives one shared prescaler counter through four blink rates. Rate changes happen only at half-period boundaries, so the LED never glitches. In auto mode it steps through the rates on its own after a fixed number of toggles. It replaces the four free-running per-rate counters and the switch multiplexer with a single sequenced counter.

---
 rtl/led_rate_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_led_rate_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/led_rate_scheduler.sv
// rtl/led_rate_scheduler.sv - sequenced single-counter LED blink rate scheduler
//
// Purpose: conditions four asynchronous control inputs (2-flop synchronizer
// plus debounce counter each) and drives one shared prescaler through four
// blink rates. Rate changes are applied only at half-period boundaries; in
// auto mode the rate advances after DWELL_TOGGLES LED toggles.
//
// Ports:
//   i_clock     sole clock, rising edge
//   i_reset_n   synchronous active-low reset
//   i_switch1   async rate select MSB
//   i_switch2   async rate select LSB
//   i_enable    async blink enable
//   i_auto      async auto-cycle mode select
//   o_led       registered LED drive
//   o_rate_sel  registered rate currently governing the counter
//   o_toggle    registered one-cycle pulse on each o_led transition
module led_rate_scheduler #(
   parameter int CLK_HZ          = 25000000,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int DWELL_TOGGLES   = 8
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic       i_switch1,
   input  logic       i_switch2,
   input  logic       i_enable,
   input  logic       i_auto,
   output logic       o_led,
   output logic [1:0] o_rate_sel,
   output logic       o_toggle
);

   // Terminal counts (half-period limit minus one) per rate.
   localparam logic [31:0] TC0 = 32'(CLK_HZ / 2)   - 32'd1;
   localparam logic [31:0] TC1 = 32'(CLK_HZ / 20)  - 32'd1;
   localparam logic [31:0] TC2 = 32'(CLK_HZ / 100) - 32'd1;
   localparam logic [31:0] TC3 = 32'(CLK_HZ / 200) - 32'd1;

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   localparam int DWW = $clog2(DWELL_TOGGLES + 1);
   localparam logic [DWW-1:0] DWELL_MAX = DWW'(DWELL_TOGGLES);

   // Input bit positions within the conditioned vector.
   localparam int B_SW2  = 0;
   localparam int B_SW1  = 1;
   localparam int B_EN   = 2;
   localparam int B_AUTO = 3;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // ---------------------------------------------------------------
   // Input conditioning
   // ---------------------------------------------------------------
   logic [3:0]          raw;
   logic [3:0]          sync1_q, sync2_q;
   logic [3:0]          db_q, db_d;
   logic [3:0][DBW-1:0] db_cnt_q, db_cnt_d;

   assign raw = {i_auto, i_enable, i_switch1, i_switch2};

   // The debounced bit only follows the synchronized bit after it has
   // differed for DEBOUNCE_CYCLES consecutive cycles; agreement resets
   // the count, so any bounce restarts the qualification window.
   always_comb begin
      db_d     = db_q;
      db_cnt_d = db_cnt_q;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] == db_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DB_LAST) begin
            db_d[i]     = sync2_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         db_q     <= '0;
         db_cnt_q <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         db_q     <= db_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   logic       en_db, auto_db;
   logic [1:0] req_rate;

   assign en_db    = db_q[B_EN];
   assign auto_db  = db_q[B_AUTO];
   assign req_rate = {db_q[B_SW1], db_q[B_SW2]};

   // ---------------------------------------------------------------
   // Rate sequencer
   // ---------------------------------------------------------------
   state_t         state_q, state_d;
   logic [31:0]    cnt_q, cnt_d;
   logic [DWW-1:0] dwell_q, dwell_d;
   logic [DWW-1:0] dwell_inc;
   logic [1:0]     rate_q, rate_d;
   logic           led_q, led_d;
   logic           toggle_q, toggle_d;
   // Mode seen at the last boundary; a mismatch means auto_db flipped
   // mid-half-period and the new mode takes over at this boundary.
   logic           auto_seen_q, auto_seen_d;
   logic [31:0]    tc;
   logic           terminal;

   always_comb begin
      case (rate_q)
         2'd0:    tc = TC0;
         2'd1:    tc = TC1;
         2'd2:    tc = TC2;
         default: tc = TC3;
      endcase
   end

   assign terminal  = (cnt_q == tc);
   // Saturates so manual mode can keep counting without wrapping.
   assign dwell_inc = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dwell_d     = dwell_q;
      rate_d      = rate_q;
      led_d       = led_q;
      toggle_d    = 1'b0;
      auto_seen_d = auto_seen_q;

      case (state_q)
         S_IDLE: begin
            cnt_d       = '0;
            led_d       = 1'b0;
            dwell_d     = '0;
            auto_seen_d = auto_db;
            if (!auto_db) begin
               rate_d = req_rate;
            end
            if (en_db) begin
               state_d = S_RUN;
            end
         end

         default: begin
            if (!en_db) begin
               // Disable wins over a coincident terminal count.
               state_d = S_IDLE;
               cnt_d   = '0;
               led_d   = 1'b0;
               dwell_d = '0;
            end else if (terminal) begin
               cnt_d       = '0;
               led_d       = ~led_q;
               toggle_d    = 1'b1;
               auto_seen_d = auto_db;
               if (auto_db != auto_seen_q) begin
                  dwell_d = '0;
                  if (!auto_db) begin
                     rate_d = req_rate;
                  end
               end else if (auto_db) begin
                  if (dwell_inc == DWELL_MAX) begin
                     rate_d  = rate_q + 2'd1;
                     dwell_d = '0;
                  end else begin
                     dwell_d = dwell_inc;
                  end
               end else begin
                  rate_d  = req_rate;
                  dwell_d = (req_rate != rate_q) ? '0 : dwell_inc;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dwell_q     <= '0;
         rate_q      <= '0;
         led_q       <= 1'b0;
         toggle_q    <= 1'b0;
         auto_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dwell_q     <= dwell_d;
         rate_q      <= rate_d;
         led_q       <= led_d;
         toggle_q    <= toggle_d;
         auto_seen_q <= auto_seen_d;
      end
   end

   assign o_led      = led_q;
   assign o_rate_sel = rate_q;
   assign o_toggle   = toggle_q;

endmodule

// File: tb/tb_led_rate_scheduler.sv
// tb/tb_led_rate_scheduler.sv - directed self-checking bench for led_rate_scheduler
module tb_led_rate_scheduler;

   logic       clk;
   logic       reset_n;
   logic       sw1, sw2, en, auto_m;
   logic       led;
   logic [1:0] rate;
   logic       toggle;

   int checks;
   int errors;
   int tog_cnt;
   int tc0;
   int n;

   led_rate_scheduler #(
      .CLK_HZ(2000),
      .DEBOUNCE_CYCLES(4),
      .DWELL_TOGGLES(2)
   ) dut (
      .i_clock(clk),
      .i_reset_n(reset_n),
      .i_switch1(sw1),
      .i_switch2(sw2),
      .i_enable(en),
      .i_auto(auto_m),
      .o_led(led),
      .o_rate_sel(rate),
      .o_toggle(toggle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (toggle === 1'b1) tog_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic edges(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Counts rising edges until o_toggle is seen high; bounded.
   task automatic wait_toggle(output int cycles);
      cycles = 0;
      do begin
         @(negedge clk);
         cycles++;
      end while (toggle !== 1'b1 && cycles < 3000);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      tog_cnt = 0;
      reset_n = 1'b0;
      sw1 = 1'b1; sw2 = 1'b1; en = 1'b1; auto_m = 1'b1;

      // Reset / idle
      edges(3);
      chk("reset_led", 32'(led), 0);
      chk("reset_rate", 32'(rate), 0);
      chk("reset_toggle", 32'(toggle), 0);
      reset_n = 1'b1; en = 1'b0; auto_m = 1'b0;
      edges(6);
      chk("idle_rate_before_db", 32'(rate), 0);
      edges(1);
      chk("idle_rate_tracks", 32'(rate), 3);
      edges(10);
      chk("idle_led", 32'(led), 0);
      chk("idle_no_toggles", 32'(tog_cnt), 0);

      // Manual rate 3
      en = 1'b1;
      wait_toggle(n);
      chk("manual_first_toggle", 32'(n), 17);
      chk("manual_led_after_first", 32'(led), 1);
      for (int i = 0; i < 10; i++) begin
         wait_toggle(n);
         chk($sformatf("manual_half_period_%0d", i), 32'(n), 10);
      end

      // Deferred change from rate 0 to rate 1
      en = 1'b0; sw1 = 1'b0; sw2 = 1'b0;
      edges(10);
      chk("disable_led", 32'(led), 0);
      chk("disable_rate0", 32'(rate), 0);
      en = 1'b1;
      edges(107);
      sw2 = 1'b1;
      edges(10);
      chk("deferred_rate_held", 32'(rate), 0);
      wait_toggle(n);
      chk("deferred_rate0_complete", 32'(n), 890);
      chk("deferred_rate_switch", 32'(rate), 1);
      wait_toggle(n);
      chk("deferred_rate1_half", 32'(n), 100);
      chk("deferred_rate1_hold", 32'(rate), 1);

      // Debounce in idle
      en = 1'b0;
      edges(10);
      chk("debounce_idle_led", 32'(led), 0);
      for (int i = 0; i < 12; i++) begin
         sw2 = ~sw2;
         edges(3);
      end
      edges(4);
      chk("debounce_bounce_ignored", 32'(rate), 1);
      sw2 = 1'b0;
      edges(6);
      chk("debounce_not_yet", 32'(rate), 1);
      edges(1);
      chk("debounce_accepted", 32'(rate), 0);

      // Auto cycle starting at rate 2
      sw1 = 1'b1; sw2 = 1'b0;
      edges(10);
      chk("auto_setup_rate2", 32'(rate), 2);
      auto_m = 1'b1;
      edges(10);
      chk("auto_rate_held_idle", 32'(rate), 2);
      en = 1'b1;
      wait_toggle(n);
      chk("auto_t1", 32'(n), 27);
      chk("auto_t1_rate", 32'(rate), 2);
      wait_toggle(n);
      chk("auto_t2", 32'(n), 20);
      chk("auto_t2_rate", 32'(rate), 3);
      wait_toggle(n);
      chk("auto_t3", 32'(n), 10);
      chk("auto_t3_rate", 32'(rate), 3);
      wait_toggle(n);
      chk("auto_t4", 32'(n), 10);
      chk("auto_t4_rate", 32'(rate), 0);
      wait_toggle(n);
      chk("auto_t5", 32'(n), 1000);
      chk("auto_t5_rate", 32'(rate), 0);
      wait_toggle(n);
      chk("auto_t6", 32'(n), 1000);
      chk("auto_t6_rate", 32'(rate), 1);

      // Enable drop on a terminal-count cycle
      en = 1'b0; auto_m = 1'b0; sw1 = 1'b1; sw2 = 1'b1;
      edges(20);
      chk("drop_setup_rate3", 32'(rate), 3);
      chk("drop_setup_led", 32'(led), 0);
      en = 1'b1;
      wait_toggle(n);
      chk("drop_first", 32'(n), 17);
      wait_toggle(n);
      chk("drop_second", 32'(n), 10);
      chk("drop_led_low_before", 32'(led), 0);
      edges(3);
      en = 1'b0;
      tc0 = tog_cnt;
      edges(7);
      chk("drop_tc_led", 32'(led), 0);
      chk("drop_tc_no_toggle", 32'(toggle), 0);
      edges(10);
      chk("drop_no_pulses", 32'(tog_cnt), 32'(tc0));
      en = 1'b1;
      wait_toggle(n);
      chk("reenable_first", 32'(n), 17);
      chk("reenable_rate", 32'(rate), 3);
      chk("reenable_led", 32'(led), 1);

      // Reset mid-run
      reset_n = 1'b0;
      edges(1);
      chk("midrun_reset_led", 32'(led), 0);
      chk("midrun_reset_rate", 32'(rate), 0);
      chk("midrun_reset_toggle", 32'(toggle), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
